// File: rtl/noc_node_port.sv
// rtl/noc_node_port.sv - NoC endpoint: TX packet FIFO + flit serialiser, RX flit deserialiser
//
// Optional feature macro: NODE_STATS_EN (adds tx_pkts / rx_pkts / drops counters)
//
// Ports:
//   clock, reset_n              rising-edge clock, synchronous active-low reset
//   pkt_in, pkt_in_avail        packet write into the DEPTH-entry TX FIFO
//   cQ_full                     TX FIFO holds DEPTH entries (writes dropped)
//   free_outbound               router can take a packet
//   put_outbound, payload_outbound   outbound flit stream, MS flit first
//   put_inbound, payload_inbound     inbound flit stream, MS flit first
//   free_inbound                node is idle and can take a new inbound packet
//   pkt_out, pkt_out_avail      reassembled packet, one-cycle valid pulse
//   tx_pkts, rx_pkts, drops     saturating statistics (NODE_STATS_EN only)
module noc_node_port #(
    parameter int PKT_W  = 32,
    parameter int FLIT_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [PKT_W-1:0]  pkt_in,
    input  logic              pkt_in_avail,
    output logic              cQ_full,
    output logic [PKT_W-1:0]  pkt_out,
    output logic              pkt_out_avail,
    input  logic              free_outbound,
    output logic              put_outbound,
    output logic [FLIT_W-1:0] payload_outbound,
    output logic              free_inbound,
    input  logic              put_inbound,
    input  logic [FLIT_W-1:0] payload_inbound
`ifdef NODE_STATS_EN
    ,
    output logic [15:0]       tx_pkts,
    output logic [15:0]       rx_pkts,
    output logic [15:0]       drops
`endif
);

    localparam int NFLIT = PKT_W / FLIT_W;
    localparam int CW    = $clog2(NFLIT);
    localparam int PW    = $clog2(DEPTH);
    localparam int NW    = $clog2(DEPTH + 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DONE} rx_state_t;

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PKT_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             push, pop;

    tx_state_t        tx_state_q, tx_state_d;
    logic [PKT_W-1:0] tx_shift_q, tx_shift_d;
    logic [CW-1:0]    tx_cnt_q, tx_cnt_d;

    rx_state_t        rx_state_q, rx_state_d;
    logic [PKT_W-1:0] rx_buf_q, rx_buf_d;
    logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [PKT_W-1:0] pkt_out_q, pkt_out_d;

    // FIFO + TX serialiser
    always_comb begin
        // Full is sampled from the register, so a push in the same cycle as a
        // pop on a full FIFO is dropped.
        push = pkt_in_avail && !full_q;
        // Only pop while idle; a packet written this edge is not yet in count_q.
        pop  = (tx_state_q == TX_IDLE) && (count_q != '0) && free_outbound;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = pkt_in;
        end
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == NW'(DEPTH));

        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (pop) begin
                    tx_shift_d = mem_q[rd_ptr_q];
                    tx_cnt_d   = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                // free_outbound is deliberately ignored mid-packet.
                tx_shift_d = tx_shift_q << FLIT_W;
                tx_cnt_d   = tx_cnt_q + CW'(1);
                if (tx_cnt_q == CW'(NFLIT - 1)) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX deserialiser
    always_comb begin
        rx_state_d = rx_state_q;
        rx_buf_d   = rx_buf_q;
        rx_cnt_d   = rx_cnt_q;
        pkt_out_d  = pkt_out_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (put_inbound) begin
                    rx_buf_d[PKT_W-1 -: FLIT_W] = payload_inbound;
                    rx_cnt_d   = CW'(1);
                    rx_state_d = RX_RECV;
                end
            end
            RX_RECV: begin
                if (put_inbound) begin
                    rx_buf_d[(NFLIT - 1 - int'(rx_cnt_q)) * FLIT_W +: FLIT_W] = payload_inbound;
                    rx_cnt_d = rx_cnt_q + CW'(1);
                    if (rx_cnt_q == CW'(NFLIT - 1)) begin
                        pkt_out_d  = rx_buf_d;
                        rx_state_d = RX_DONE;
                    end
                end
            end
            RX_DONE: begin
                // Any flit arriving here is a sender protocol error and is not captured.
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign cQ_full          = full_q;
    assign put_outbound     = (tx_state_q == TX_SEND);
    assign payload_outbound = (tx_state_q == TX_SEND) ? tx_shift_q[PKT_W-1 -: FLIT_W] : '0;
    assign free_inbound     = (rx_state_q == RX_IDLE);
    assign pkt_out_avail    = (rx_state_q == RX_DONE);
    assign pkt_out          = pkt_out_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            rx_buf_q   <= '0;
            rx_cnt_q   <= '0;
            pkt_out_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_state_q <= rx_state_d;
            rx_buf_q   <= rx_buf_d;
            rx_cnt_q   <= rx_cnt_d;
            pkt_out_q  <= pkt_out_d;
        end
    end

    rx_no_flit_in_done: assert property (@(posedge clock) disable iff (!reset_n)
        !(put_inbound && rx_state_q == RX_DONE));

`ifdef NODE_STATS_EN
    logic [15:0] tx_pkts_q, tx_pkts_d, rx_pkts_q, rx_pkts_d, drops_q, drops_d;

    always_comb begin
        tx_pkts_d = tx_pkts_q;
        rx_pkts_d = rx_pkts_q;
        drops_d   = drops_q;
        if (tx_state_q == TX_SEND && tx_cnt_q == CW'(NFLIT - 1) && tx_pkts_q != 16'hFFFF) begin
            tx_pkts_d = tx_pkts_q + 16'd1;
        end
        if (rx_state_q == RX_DONE && rx_pkts_q != 16'hFFFF) begin
            rx_pkts_d = rx_pkts_q + 16'd1;
        end
        if (pkt_in_avail && full_q && drops_q != 16'hFFFF) begin
            drops_d = drops_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_pkts_q <= '0;
            rx_pkts_q <= '0;
            drops_q   <= '0;
        end else begin
            tx_pkts_q <= tx_pkts_d;
            rx_pkts_q <= rx_pkts_d;
            drops_q   <= drops_d;
        end
    end

    assign tx_pkts = tx_pkts_q;
    assign rx_pkts = rx_pkts_q;
    assign drops   = drops_q;
`endif

endmodule

// File: tb/tb_noc_node_port.sv
// tb/tb_noc_node_port.sv - self-checking bench for noc_node_port (PKT_W=32, FLIT_W=8, DEPTH=4)
module tb_noc_node_port;

    logic        clock;
    logic        reset_n;
    logic [31:0] pkt_in;
    logic        pkt_in_avail;
    logic        cQ_full;
    logic [31:0] pkt_out;
    logic        pkt_out_avail;
    logic        free_outbound;
    logic        put_outbound;
    logic [7:0]  payload_outbound;
    logic        free_inbound;
    logic        put_inbound;
    logic [7:0]  payload_inbound;
`ifdef NODE_STATS_EN
    logic [15:0] tx_pkts, rx_pkts, drops;
`endif

    noc_node_port #(.PKT_W(32), .FLIT_W(8), .DEPTH(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pkt_in           (pkt_in),
        .pkt_in_avail     (pkt_in_avail),
        .cQ_full          (cQ_full),
        .pkt_out          (pkt_out),
        .pkt_out_avail    (pkt_out_avail),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .free_inbound     (free_inbound),
        .put_inbound      (put_inbound),
        .payload_inbound  (payload_inbound)
`ifdef NODE_STATS_EN
        ,
        .tx_pkts          (tx_pkts),
        .rx_pkts          (rx_pkts),
        .drops            (drops)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Outbound monitor: reassembles flits into packets, counts flit cycles.
    logic [31:0] acc;
    int          acc_n    = 0;
    int          put_seen = 0;
    logic [31:0] tx_q[$];

    always @(negedge clock) begin
        if (!reset_n) begin
            acc_n <= 0;
        end else if (put_outbound) begin
            put_seen <= put_seen + 1;
            if (acc_n == 3) begin
                tx_q.push_back({acc[23:0], payload_outbound});
                acc_n <= 0;
            end else begin
                acc   <= {acc[23:0], payload_outbound};
                acc_n <= acc_n + 1;
            end
        end
    end

    typedef struct {
        logic        rst_n;
        logic [31:0] pin;
        logic        pav;
        logic        fout;
        logic        pi;
        logic [7:0]  pl;
        logic        e_full;
        logic        e_put;
        logic [7:0]  e_pay;
        logic        e_free;
        logic        e_avail;
        logic [31:0] e_pkt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    function automatic vec_t mk(logic r, logic [31:0] pin, logic pav, logic fo, logic pi,
                                logic [7:0] pl, logic ef, logic ep, logic [7:0] ey,
                                logic efr, logic ea, logic [31:0] ek);
        vec_t v;
        v.rst_n = r;  v.pin = pin; v.pav = pav; v.fout = fo; v.pi = pi; v.pl = pl;
        v.e_full = ef; v.e_put = ep; v.e_pay = ey; v.e_free = efr; v.e_avail = ea; v.e_pkt = ek;
        return v;
    endfunction

    int base;
    int ps;
    logic [31:0] exp_b [5];

    initial begin
        reset_n = 1'b0; pkt_in = '0; pkt_in_avail = 1'b0; free_outbound = 1'b0;
        put_inbound = 1'b0; payload_inbound = '0;

        //           rst pkt_in        av fo pi pl    | full put pay   free av pkt_out
        vecs[0]  = mk(0, 32'h0,        0, 0, 0, 8'h00,  0,  0, 8'h00, 1,  0, 32'h0);
        vecs[1]  = mk(1, 32'hDEADBEEF, 1, 1, 0, 8'h00,  0,  0, 8'h00, 1,  0, 32'h0);
        vecs[2]  = mk(1, 32'h0,        0, 1, 0, 8'h00,  0,  1, 8'hDE, 1,  0, 32'h0);
        vecs[3]  = mk(1, 32'h0,        0, 1, 0, 8'h00,  0,  1, 8'hAD, 1,  0, 32'h0);
        vecs[4]  = mk(1, 32'h0,        0, 1, 0, 8'h00,  0,  1, 8'hBE, 1,  0, 32'h0);
        vecs[5]  = mk(1, 32'h0,        0, 1, 0, 8'h00,  0,  1, 8'hEF, 1,  0, 32'h0);
        vecs[6]  = mk(1, 32'h0,        0, 1, 0, 8'h00,  0,  0, 8'h00, 1,  0, 32'h0);
        vecs[7]  = mk(1, 32'h0,        0, 0, 1, 8'h12,  0,  0, 8'h00, 0,  0, 32'h0);
        vecs[8]  = mk(1, 32'h0,        0, 0, 1, 8'h34,  0,  0, 8'h00, 0,  0, 32'h0);
        vecs[9]  = mk(1, 32'h0,        0, 0, 0, 8'h00,  0,  0, 8'h00, 0,  0, 32'h0);
        vecs[10] = mk(1, 32'h0,        0, 0, 1, 8'h56,  0,  0, 8'h00, 0,  0, 32'h0);
        vecs[11] = mk(1, 32'h0,        0, 0, 1, 8'h78,  0,  0, 8'h00, 0,  1, 32'h12345678);
        vecs[12] = mk(1, 32'h0,        0, 0, 0, 8'h00,  0,  0, 8'h00, 1,  0, 32'h12345678);
        vecs[13] = mk(1, 32'hA5A5A5A5, 1, 1, 0, 8'h00,  0,  0, 8'h00, 1,  0, 32'h12345678);
        vecs[14] = mk(1, 32'h0,        0, 1, 1, 8'h0F,  0,  1, 8'hA5, 0,  0, 32'h12345678);
        vecs[15] = mk(1, 32'h0,        0, 1, 1, 8'h0F,  0,  1, 8'hA5, 0,  0, 32'h12345678);
        vecs[16] = mk(1, 32'h0,        0, 1, 1, 8'h0F,  0,  1, 8'hA5, 0,  0, 32'h12345678);
        vecs[17] = mk(1, 32'h0,        0, 1, 1, 8'h0F,  0,  1, 8'hA5, 0,  1, 32'h0F0F0F0F);
        vecs[18] = mk(1, 32'h0,        0, 1, 0, 8'h00,  0,  0, 8'h00, 1,  0, 32'h0F0F0F0F);

        for (int i = 0; i < NV; i++) begin
            reset_n = vecs[i].rst_n; pkt_in = vecs[i].pin; pkt_in_avail = vecs[i].pav;
            free_outbound = vecs[i].fout; put_inbound = vecs[i].pi; payload_inbound = vecs[i].pl;
            step();
            chk($sformatf("v%0d.cQ_full", i),          32'(cQ_full),          32'(vecs[i].e_full));
            chk($sformatf("v%0d.put_outbound", i),     32'(put_outbound),     32'(vecs[i].e_put));
            chk($sformatf("v%0d.payload_outbound", i), 32'(payload_outbound), 32'(vecs[i].e_pay));
            chk($sformatf("v%0d.free_inbound", i),     32'(free_inbound),     32'(vecs[i].e_free));
            chk($sformatf("v%0d.pkt_out_avail", i),    32'(pkt_out_avail),    32'(vecs[i].e_avail));
            chk($sformatf("v%0d.pkt_out", i),          pkt_out,               vecs[i].e_pkt);
        end
        put_inbound = 1'b0; pkt_in_avail = 1'b0;

        // Fill with router blocked, fifth write dropped, then drain in order.
        base = tx_q.size();
        free_outbound = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pkt_in = 32'h11111111 * (k + 1); pkt_in_avail = 1'b1;
            step();
            chk($sformatf("fill%0d.cQ_full", k), 32'(cQ_full), (k >= 3) ? 32'd1 : 32'd0);
        end
        pkt_in_avail = 1'b0; free_outbound = 1'b1;
        repeat (30) step();
        chk("drain.count", tx_q.size() - base, 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (tx_q.size() > base + k)
                chk($sformatf("drain.pkt%0d", k), tx_q[base + k], 32'h11111111 * (k + 1));
        end
        chk("drain.cQ_full", 32'(cQ_full), 32'd0);
`ifdef NODE_STATS_EN
        chk("statsA.drops",   32'(drops),   32'd1);
        chk("statsA.tx_pkts", 32'(tx_pkts), 32'd6);
        chk("statsA.rx_pkts", 32'(rx_pkts), 32'd2);
`endif

        // Full FIFO: pop and push in the same cycle, push must be dropped.
        base = tx_q.size();
        free_outbound = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pkt_in = 32'hB0000001 + k; pkt_in_avail = 1'b1;
            step();
        end
        chk("pp.full_before", 32'(cQ_full), 32'd1);
        pkt_in = 32'h99999999; pkt_in_avail = 1'b1; free_outbound = 1'b1;
        step();
        chk("pp.cQ_full_after_pop", 32'(cQ_full), 32'd0);
        chk("pp.put_outbound", 32'(put_outbound), 32'd1);
        chk("pp.first_flit", 32'(payload_outbound), 32'hB0);
        pkt_in = 32'hAAAA0001; pkt_in_avail = 1'b1; free_outbound = 1'b0;
        step();
        chk("pp.refill_full", 32'(cQ_full), 32'd1);
        pkt_in_avail = 1'b0; free_outbound = 1'b1;
        repeat (40) step();
        exp_b[0] = 32'hB0000001; exp_b[1] = 32'hB0000002; exp_b[2] = 32'hB0000003;
        exp_b[3] = 32'hB0000004; exp_b[4] = 32'hAAAA0001;
        chk("pp.count", tx_q.size() - base, 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (tx_q.size() > base + k)
                chk($sformatf("pp.pkt%0d", k), tx_q[base + k], exp_b[k]);
        end
`ifdef NODE_STATS_EN
        chk("statsB.drops",   32'(drops),   32'd2);
        chk("statsB.tx_pkts", 32'(tx_pkts), 32'd11);
`endif

        // Reset in the middle of 32'hCAFEF00D with a full FIFO behind it.
        free_outbound = 1'b0;
        pkt_in = 32'hCAFEF00D; pkt_in_avail = 1'b1; step();
        pkt_in = 32'h00000011; step();
        pkt_in = 32'h00000022; step();
        pkt_in = 32'h00000033; step();
        pkt_in_avail = 1'b0; free_outbound = 1'b1;
        step();
        chk("rst.flit0", 32'(payload_outbound), 32'hCA);
        step();
        chk("rst.flit1", 32'(payload_outbound), 32'hFE);
        reset_n = 1'b0;
        step();
        chk("rst.put_outbound", 32'(put_outbound), 32'd0);
        chk("rst.payload", 32'(payload_outbound), 32'd0);
        chk("rst.cQ_full", 32'(cQ_full), 32'd0);
        chk("rst.free_inbound", 32'(free_inbound), 32'd1);
        chk("rst.pkt_out", pkt_out, 32'd0);
        reset_n = 1'b1;
        ps = put_seen;
        repeat (10) step();
        chk("rst.no_flits_after", 32'(put_seen - ps), 32'd0);
`ifdef NODE_STATS_EN
        chk("statsC.drops",   32'(drops),   32'd0);
        chk("statsC.tx_pkts", 32'(tx_pkts), 32'd0);
        chk("statsC.rx_pkts", 32'(rx_pkts), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
